// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the 32-byte GPU memory combinator/separator pair.
// A combined line is 2*LANES words of W bits; each word carries one weight byte and one payload byte.
package gpu_mem_pkg;

  localparam int LANES  = 8;
  localparam int W      = 16;
  localparam int NWORDS = 2 * LANES;
  localparam int LINE_W = NWORDS * W;
  localparam int WT_W   = NWORDS * 8;
  localparam int IDX_W  = $clog2(LANES);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/gpu_mem_split_word.sv
// Splits one combined word into its weight high byte and its payload byte.
module gpu_mem_split_word
  import gpu_mem_pkg::*;
(
  input  logic [W-1:0] word,
  output logic [7:0]   hi,
  output logic [7:0]   lo
);

  assign hi = word[15:8];
  assign lo = word[7:0];

endmodule

// File: rtl/gpu_mem_separator_32b.sv
// Receive-side separator: captures one combined line, presents its weight bytes as a held
// sideband and streams the LANES rebuilt payload words out one per accepted cycle.
module gpu_mem_separator_32b
  import gpu_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [LINE_W-1:0] io_in_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [W-1:0]      io_out_payload,
  output logic [IDX_W-1:0]  io_out_index,
  output logic              io_out_last,
  output logic [WT_W-1:0]   io_weights_hi,
  output logic              io_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t                     state, state_next;
  line_t                      line_q;
  logic [IDX_W-1:0]           index_q, index_next;
  logic                       load;
  logic [NWORDS-1:0][7:0]     hi_bytes;
  logic [NWORDS-1:0][7:0]     lo_bytes;

  for (genvar j = 0; j < NWORDS; j++) begin : g_split
    gpu_mem_split_word u_split (
      .word (line_q[j*W +: W]),
      .hi   (hi_bytes[j]),
      .lo   (lo_bytes[j])
    );
  end

  // Even word carries the payload high byte, the following odd word the low byte.
  assign io_out_payload = {lo_bytes[{index_q, 1'b0}], lo_bytes[{index_q, 1'b1}]};
  assign io_weights_hi  = hi_bytes;
  assign io_out_index   = index_q;
  assign io_out_valid   = (state == DRAIN);
  assign io_busy        = (state == DRAIN);
  assign io_out_last    = (state == DRAIN) && (index_q == LAST_IDX);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_next  = state;
    index_next  = index_q;
    load        = 1'b0;
    io_in_ready = 1'b0;
    case (state)
      IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          load       = 1'b1;
          index_next = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (io_out_ready) begin
          if (index_q == LAST_IDX) begin
            // Final word leaves this edge, so a waiting line can be taken on the same edge.
            io_in_ready = 1'b1;
            index_next  = '0;
            if (io_in_valid) load = 1'b1;
            else             state_next = IDLE;
          end else begin
            index_next = index_q + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) io_in_ready = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      index_q <= '0;
      // NOTE: the line register is reset because the payload and weight outputs read it directly.
      line_q  <= '0;
    end else begin
      state   <= state_next;
      index_q <= index_next;
      if (load) line_q <= io_in_data;
    end
  end

endmodule

// File: tb/tb_gpu_mem_separator_32b.sv
// Directed bench for gpu_mem_separator_32b: expected payload words are queued when a line is
// accepted and compared in order as the block emits them.
module tb_gpu_mem_separator_32b;
  import gpu_mem_pkg::*;

  typedef logic [LANES-1:0][W-1:0]  pl_vec_t;
  typedef logic [NWORDS-1:0][W-1:0] word_vec_t;
  typedef struct packed {
    logic [W-1:0]     payload;
    logic [IDX_W-1:0] index;
    logic             last;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_in_valid = 1'b0;
  logic              io_in_ready;
  logic [LINE_W-1:0] io_in_data = '0;
  logic              io_out_valid;
  logic              io_out_ready = 1'b1;
  logic [W-1:0]      io_out_payload;
  logic [IDX_W-1:0]  io_out_index;
  logic              io_out_last;
  logic [WT_W-1:0]   io_weights_hi;
  logic              io_busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_words = 0;
  int   valid_cycles = 0;
  int   ready_in_drain = 0;

  gpu_mem_separator_32b dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_data     (io_in_data),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_payload (io_out_payload),
    .io_out_index   (io_out_index),
    .io_out_last    (io_out_last),
    .io_weights_hi  (io_weights_hi),
    .io_busy        (io_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Forward packing of the combinator: word 2i = {w hi, payload hi}, word 2i+1 = {w hi, payload lo}.
  function automatic line_t combine(input pl_vec_t pl, input word_vec_t wt);
    line_t l;
    for (int i = 0; i < LANES; i++) begin
      l[(2*i)*W +: W]   = {wt[2*i][15:8], pl[i][15:8]};
      l[(2*i+1)*W +: W] = {wt[2*i+1][15:8], pl[i][7:0]};
    end
    return l;
  endfunction

  function automatic logic [WT_W-1:0] hi_of(input word_vec_t wt);
    logic [WT_W-1:0] h;
    for (int j = 0; j < NWORDS; j++) h[8*j +: 8] = wt[j][15:8];
    return h;
  endfunction

  // Output monitor / scoreboard consumer, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (io_out_valid) valid_cycles++;
      if (io_out_valid && io_in_ready) ready_in_drain++;
      if (io_out_valid && io_out_ready) begin
        n_words++;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_payload", io_out_payload, e.payload);
          check("out_index", io_out_index, e.index);
          check("out_last", io_out_last, e.last);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the line.
  task automatic send_line(input line_t data, input pl_vec_t exp_pl);
    bit ok;
    ok = 1'b0;
    io_in_valid = 1'b1;
    io_in_data  = data;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (io_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    if (ok) begin
      for (int i = 0; i < LANES; i++) sb.push_back('{exp_pl[i], IDX_W'(i), (i == LANES - 1)});
    end
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!io_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", ok, 1);
    check("sb_empty", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_index(input logic [IDX_W-1:0] idx);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (io_out_valid && io_out_index == idx) begin
        ok = 1'b1;
        break;
      end
    end
    check("index_timeout", ok, 1);
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", io_out_valid, 0);
    check("rst_in_ready", io_in_ready, 0);
    check("rst_index", io_out_index, 0);
    check("rst_last", io_out_last, 0);
    check("rst_payload", io_out_payload, 0);
    check("rst_weights", io_weights_hi, 0);
    check("rst_busy", io_busy, 0);
  endtask

  initial begin
    word_vec_t       w, wa, wb;
    pl_vec_t         pl, pa, pb;
    logic [WT_W-1:0] wexp;
    int              words_before;

    // Reset state
    repeat (2) begin
      @(negedge clock);
      check_reset_values();
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", io_in_ready, 1);
    check("post_rst_valid", io_out_valid, 0);
    @(posedge clock);
    #1;

    // Single line
    w = '0;
    w[0] = 16'hAB12;
    w[1] = 16'hCD34;
    pl = '0;
    pl[0] = 16'h1234;
    send_line(line_t'(w), pl);
    wexp = '0;
    wexp[15:0] = 16'hCDAB;
    check("single_weights", io_weights_hi, wexp);
    @(negedge clock);
    check("single_latency_valid", io_out_valid, 1);
    check("single_latency_index", io_out_index, 0);
    check("single_latency_payload", io_out_payload, 16'h1234);
    wait_idle();

    // Backpressure at index 2
    for (int i = 0; i < LANES; i++) pl[i] = 16'h3A00 + W'(i * 16'h0111);
    for (int j = 0; j < NWORDS; j++) w[j] = W'($urandom);
    words_before = n_words;
    send_line(combine(pl, w), pl);
    wait_index(IDX_W'(1));
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("bp_valid", io_out_valid, 1);
      check("bp_index", io_out_index, 2);
      check("bp_payload", io_out_payload, pl[2]);
      @(posedge clock);
      #1;
    end
    io_out_ready = 1'b1;
    wait_idle();
    check("bp_word_count", n_words - words_before, LANES);

    // Back-to-back lines
    for (int j = 0; j < NWORDS; j++) begin
      wa[j] = 16'h1100 + W'(j);
      wb[j] = 16'h2200 + W'(j);
    end
    for (int i = 0; i < LANES; i++) begin
      pa[i] = {8'(2 * i), 8'(2 * i + 1)};
      pb[i] = {8'(2 * i), 8'(2 * i + 1)};
    end
    valid_cycles   = 0;
    ready_in_drain = 0;
    send_line(line_t'(wa), pa);
    check("b2b_weights_a", io_weights_hi, {NWORDS{8'h11}});
    send_line(line_t'(wb), pb);
    check("b2b_weights_b", io_weights_hi, {NWORDS{8'h22}});
    wait_idle();
    check("b2b_valid_cycles", valid_cycles, 2 * LANES);
    check("b2b_ready_pulses", ready_in_drain, 2);

    // Idle hold
    repeat (10) begin
      @(negedge clock);
      check("idle_valid", io_out_valid, 0);
      check("idle_busy", io_busy, 0);
      check("idle_weights", io_weights_hi, {NWORDS{8'h22}});
    end
    @(posedge clock);
    #1;

    // Round-trip through the combinator packing
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LANES; i++) pl[i] = W'($urandom);
      for (int j = 0; j < NWORDS; j++) w[j] = W'($urandom);
      send_line(combine(pl, w), pl);
      check("rt_weights", io_weights_hi, hi_of(w));
    end
    wait_idle();

    // Reset mid-drain at index 4
    for (int i = 0; i < LANES; i++) pl[i] = W'($urandom);
    for (int j = 0; j < NWORDS; j++) w[j] = W'($urandom);
    send_line(combine(pl, w), pl);
    wait_index(IDX_W'(3));
    @(posedge clock);
    #1;
    check("pre_rst_index", io_out_index, 4);
    reset = 1'b1;
    sb.delete();
    #2;
    check_reset_values();
    @(negedge clock);
    check("mid_rst_valid", io_out_valid, 0);
    check("mid_rst_in_ready", io_in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rel_valid", io_out_valid, 0);
    check("rel_in_ready", io_in_ready, 1);
    @(posedge clock);
    #1;
    for (int i = 0; i < LANES; i++) pl[i] = W'($urandom);
    for (int j = 0; j < NWORDS; j++) w[j] = W'($urandom);
    send_line(combine(pl, w), pl);
    check("fresh_weights", io_weights_hi, hi_of(w));
    @(negedge clock);
    check("fresh_index0", io_out_index, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
